morse_sequencer: RTL and testbench

//  Upstream keying source for the CW transmitter stage. Steps through a message table of Morse

---
 rtl/morse_sequencer_pkg.sv | 40 ++++
 rtl/morse_sequencer_unit_timer.sv | 44 ++++
 rtl/morse_sequencer.sv | 162 ++++++++++++++++
 tb/tb_morse_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_sequencer_pkg.sv
// Shared definitions for the Morse keying sequencer: entry fields, unit timing, states, codes.
// No logic of its own; imported by the sequencer, its unit timer and the bench.
// Entry byte: [7:5] element count (0/6/7 = word space), [4:0] elements, bit0 first, 1 = dash.
package morse_sequencer_pkg;

    localparam int ENT_N_HI  = 7;
    localparam int ENT_N_LO  = 5;
    localparam int ENT_EL_HI = 4;
    localparam int ENT_EL_LO = 0;

    // Durations in Morse units
    localparam logic [7:0] DOT_U        = 8'd1;
    localparam logic [7:0] DASH_U       = 8'd3;
    localparam logic [7:0] ELEM_GAP_U   = 8'd1;
    localparam logic [7:0] CHAR_GAP_U   = 8'd3;
    localparam logic [7:0] WORD_EXTRA_U = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_MARK     = 3'd2,
        ST_SPACE    = 3'd3,
        ST_CHAR_GAP = 3'd4,
        ST_WORD_GAP = 3'd5,
        ST_MSG_GAP  = 3'd6
    } state_t;

    localparam logic [7:0] CODE_E     = 8'h20;
    localparam logic [7:0] CODE_T     = 8'h21;
    localparam logic [7:0] CODE_A     = 8'h42;
    localparam logic [7:0] CODE_C     = 8'h85;
    localparam logic [7:0] CODE_Q     = 8'h8B;
    localparam logic [7:0] CODE_SPACE = 8'h00;

    // Element counts 1..5 are real characters; everything else is keyed as a word space
    function automatic logic is_char(input logic [2:0] n);
        return (n >= 3'd1) && (n <= 3'd5);
    endfunction

endpackage

// File: rtl/morse_sequencer_unit_timer.sv
// Unit timer: prescaler of DOT_DIV cycles per unit plus an 8-bit unit down-counter.
// load restarts both; done is high in the last cycle of a units*DOT_DIV interval.
// No backpressure; free-running between loads.
module morse_unit_timer #(
    parameter int DOT_DIV = 4194304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] units,
    output logic       done
);

    localparam int PRE_W = (DOT_DIV > 2) ? $clog2(DOT_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DOT_DIV - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             tick;

    // Next prescaler and unit count; a load always wins so every state starts from zero
    always_comb begin
        tick    = (presc_q == PRE_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = (tick && (cnt_q != 8'd0)) ? cnt_q - 8'd1 : cnt_q;
        if (load) begin
            presc_d = '0;
            cnt_d   = units;
        end
        done = tick && (cnt_q == 8'd1);
    end

    // Timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= 8'd0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Steps through a packed Morse message table and drives the registered CW key line.
// key rises the cycle after LOAD; every timed state lasts units*DOT_DIV cycles.
// en is honoured only at character boundaries and at the end of the message gap.
module morse_sequencer
    import morse_sequencer_pkg::*;
#(
    parameter int                    DOT_DIV    = 4194304,
    parameter int                    MSG_LEN    = 3,
    parameter int                    IDX_W      = 2,
    parameter logic [8*MSG_LEN-1:0]  MSG        = 24'h00_8B_85,
    parameter int                    REPEAT_GAP = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             key,
    output logic             busy,
    output logic             char_strobe,
    output logic             msg_done,
    output logic [IDX_W-1:0] char_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] char_idx_q, char_idx_d;
    logic [4:0]       elems_q, elems_d;
    logic [2:0]       remain_q, remain_d;
    logic             key_q, key_d;
    logic             busy_q, busy_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;

    logic [7:0] entry;
    logic [7:0] units;
    logic       tmr_load;
    logic       tmr_done;

    morse_unit_timer #(
        .DOT_DIV (DOT_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .units (units),
        .done  (tmr_done)
    );

    // Next-state, element bookkeeping, table mux and next output values
    always_comb begin
        state_d    = state_q;
        char_idx_d = char_idx_q;
        elems_d    = elems_q;
        remain_d   = remain_q;
        units      = DOT_U;

        case (state_q)
            ST_IDLE: begin
                char_idx_d = '0;
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (is_char(remain_q)) begin
                    state_d = ST_MARK;
                    units   = elems_q[0] ? DASH_U : DOT_U;
                end else begin
                    state_d = ST_WORD_GAP;
                    units   = WORD_EXTRA_U;
                end
            end
            ST_MARK: begin
                if (tmr_done) begin
                    elems_d  = elems_q >> 1;
                    remain_d = remain_q - 3'd1;
                    if (remain_q > 3'd1) begin
                        state_d = ST_SPACE;
                        units   = ELEM_GAP_U;
                    end else begin
                        state_d = ST_CHAR_GAP;
                        units   = CHAR_GAP_U;
                    end
                end
            end
            ST_SPACE: begin
                if (tmr_done) begin
                    state_d = ST_MARK;
                    units   = elems_q[0] ? DASH_U : DOT_U;
                end
            end
            ST_CHAR_GAP, ST_WORD_GAP: begin
                if (tmr_done) begin
                    if (char_idx_q == LAST_IDX) begin
                        state_d    = ST_MSG_GAP;
                        char_idx_d = '0;
                        units      = 8'(REPEAT_GAP);
                    end else if (!en) begin
                        state_d    = ST_IDLE;
                        char_idx_d = '0;
                    end else begin
                        state_d    = ST_LOAD;
                        char_idx_d = char_idx_q + 1'b1;
                    end
                end
            end
            ST_MSG_GAP: begin
                if (tmr_done) state_d = en ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                char_idx_d = '0;
            end
        endcase

        // Table entry for the index the FSM is about to hold
        entry = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (char_idx_d == IDX_W'(i)) entry = MSG[8*i +: 8];
        end

        // Entry is captured on the way into LOAD so LOAD can branch on it
        if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
            elems_d  = entry[ENT_EL_HI:ENT_EL_LO];
            remain_d = entry[ENT_N_HI:ENT_N_LO];
        end

        tmr_load = (state_d != state_q);
        key_d    = (state_d == ST_MARK);
        busy_d   = (state_d != ST_IDLE);
        strobe_d = (state_d == ST_LOAD) && is_char(entry[ENT_N_HI:ENT_N_LO]);
        done_d   = (state_d == ST_MSG_GAP) && (state_q != ST_MSG_GAP);
    end

    // FSM state and registered outputs; reset drops key without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            char_idx_q <= '0;
            elems_q    <= 5'd0;
            remain_q   <= 3'd0;
            key_q      <= 1'b0;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            char_idx_q <= char_idx_d;
            elems_q    <= elems_d;
            remain_q   <= remain_d;
            key_q      <= key_d;
            busy_q     <= busy_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
        end
    end

    assign key         = key_q;
    assign busy        = busy_q;
    assign char_strobe = strobe_q;
    assign msg_done    = done_q;
    assign char_idx    = char_idx_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: five instances with different message tables, DOT_DIV=4.
// Key run lengths (positive = on, negative = off) and strobe indices are captured and
// compared against expected tables queued when en is driven.
module tb_morse_sequencer;
    import morse_sequencer_pkg::*;

    typedef struct {
        int inst;
        int kind;   // 0 = key run length, 1 = char_strobe index
        int val;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] en  = 5'b0;
    logic [4:0] key_w, busy_w, stb_w, done_w;
    logic [1:0] idx_w [5];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int   run_q [5][$];
    int   stb_q [5][$];
    int   run_len [5];
    logic prev_key [5];
    logic seen_rise [5];
    int   done_cnt [5];

    vec_t exp_q [$];

    always #5 clk = ~clk;

    morse_sequencer #(.DOT_DIV(4), .MSG_LEN(1), .IDX_W(2), .MSG(CODE_E), .REPEAT_GAP(7)) u_e (
        .clk(clk), .rst(rst), .en(en[0]), .key(key_w[0]), .busy(busy_w[0]),
        .char_strobe(stb_w[0]), .msg_done(done_w[0]), .char_idx(idx_w[0]));
    morse_sequencer #(.DOT_DIV(4), .MSG_LEN(1), .IDX_W(2), .MSG(CODE_T), .REPEAT_GAP(7)) u_t (
        .clk(clk), .rst(rst), .en(en[1]), .key(key_w[1]), .busy(busy_w[1]),
        .char_strobe(stb_w[1]), .msg_done(done_w[1]), .char_idx(idx_w[1]));
    morse_sequencer #(.DOT_DIV(4), .MSG_LEN(1), .IDX_W(2), .MSG(CODE_A), .REPEAT_GAP(7)) u_a (
        .clk(clk), .rst(rst), .en(en[2]), .key(key_w[2]), .busy(busy_w[2]),
        .char_strobe(stb_w[2]), .msg_done(done_w[2]), .char_idx(idx_w[2]));
    morse_sequencer #(.DOT_DIV(4), .MSG_LEN(3), .IDX_W(2), .MSG({CODE_E, CODE_SPACE, CODE_E}),
                      .REPEAT_GAP(7)) u_ee (
        .clk(clk), .rst(rst), .en(en[3]), .key(key_w[3]), .busy(busy_w[3]),
        .char_strobe(stb_w[3]), .msg_done(done_w[3]), .char_idx(idx_w[3]));
    morse_sequencer #(.DOT_DIV(4), .REPEAT_GAP(7)) u_def (
        .clk(clk), .rst(rst), .en(en[4]), .key(key_w[4]), .busy(busy_w[4]),
        .char_strobe(stb_w[4]), .msg_done(done_w[4]), .char_idx(idx_w[4]));

    // Monitor: run lengths start at the first rising key edge of each instance
    initial begin
        for (int i = 0; i < 5; i++) begin
            run_len[i] = 0; prev_key[i] = 1'b0; seen_rise[i] = 1'b0; done_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 5; i++) begin
                if (key_w[i] !== prev_key[i]) begin
                    if (seen_rise[i]) run_q[i].push_back(prev_key[i] ? run_len[i] : -run_len[i]);
                    if (key_w[i] === 1'b1) seen_rise[i] = 1'b1;
                    prev_key[i] = key_w[i];
                    run_len[i]  = 1;
                end else begin
                    run_len[i]++;
                end
                if (stb_w[i] === 1'b1) stb_q[i].push_back(int'(idx_w[i]));
                if (done_w[i] === 1'b1) done_cnt[i]++;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_tbl(input int inst, input int kind, input int vals[$]);
        foreach (vals[k]) exp_q.push_back('{inst: inst, kind: kind, val: vals[k]});
    endtask

    // Pop every expected record and compare with what the monitor captured
    task automatic drain(input string phase);
        vec_t v;
        int   act;
        int   n;
        n = 0;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            act = 32'h7fffffff;
            if (v.kind == 0) begin
                if (run_q[v.inst].size() > 0) act = run_q[v.inst].pop_front();
            end else begin
                if (stb_q[v.inst].size() > 0) act = stb_q[v.inst].pop_front();
            end
            check($sformatf("%s inst%0d %s#%0d", phase, v.inst, (v.kind == 0) ? "run" : "strobe", n),
                  act, v.val);
            n++;
        end
    endtask

    initial begin
        int t0, n, c, base, fall_at, found;
        logic key_seen, prev_k;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset key all", int'(key_w), 0);
        check("reset busy all", int'(busy_w), 0);
        check("reset strobe", int'(stb_w[4]), 0);
        check("reset msg_done", int'(done_w[4]), 0);
        check("reset char_idx", int'(idx_w[4]), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle with en=0", int'(busy_w), 0);

        // All instances run; off runs include the 1-cycle LOAD before the next mark
        push_tbl(0, 0, '{4, -41, 4});
        push_tbl(1, 0, '{12, -41, 12});
        push_tbl(2, 0, '{4, -4, 12, -41, 4});
        // E, then CHAR_GAP 12 + LOAD 1 + WORD_GAP 16 + LOAD 1 before the second E
        push_tbl(3, 0, '{4, -30, 4, -41, 4});
        push_tbl(3, 1, '{0, 2, 0});
        push_tbl(4, 0, '{12, -4, 4, -4, 12, -4, 4, -13,
                         12, -4, 12, -4, 4, -4, 12, -58, 12});
        push_tbl(4, 1, '{0, 1, 0, 1});
        base = done_cnt[4];
        t0 = cyc;
        en = 5'b11111;

        // Single E: strobe, key timing and msg_done spacing
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (stb_w[0] === 1'b1) found = 1;
        end
        check("E strobe seen", found, 1);
        check("E key low during LOAD", int'(key_w[0]), 0);
        @(negedge clk);
        check("E strobe one cycle", int'(stb_w[0]), 0);
        check("E key rises after LOAD", int'(key_w[0]), 1);
        n = 0;
        while (key_w[0] === 1'b1 && n < 20) begin n++; @(negedge clk); end
        check("E key on cycles", n, 4);
        c = 0;
        while (done_w[0] !== 1'b1 && c < 60) begin @(negedge clk); c++; end
        check("E msg_done after key fall", c, 12);
        @(negedge clk);
        check("E msg_done one cycle", int'(done_w[0]), 0);

        while (cyc < t0 + 300) @(negedge clk);
        drain("run");
        check("default msg_done per pass", done_cnt[4] - base, 1);

        // Asynchronous reset in the middle of a mark
        found = 0;
        for (int k = 0; k < 250 && found == 0; k++) begin
            @(negedge clk);
            if (key_w[4] === 1'b1 && idx_w[4] == 2'd1) found = 1;
        end
        check("mark at idx1 found", found, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst key", int'(key_w[4]), 0);
        check("async rst busy", int'(busy_w[4]), 0);
        check("async rst char_idx", int'(idx_w[4]), 0);
        en = 5'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post-reset idle busy", int'(busy_w), 0);
        check("post-reset idle key", int'(key_w), 0);

        // en dropped mid-dash of the first C: C completes, then IDLE, Q never starts
        for (int i = 0; i < 5; i++) begin
            run_q[i].delete(); stb_q[i].delete(); seen_rise[i] = 1'b0;
        end
        push_tbl(4, 0, '{12, -4, 4, -4, 12, -4, 4});
        push_tbl(4, 1, '{0});
        en[4] = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (key_w[4] === 1'b1) found = 1;
        end
        check("C first mark", found, 1);
        repeat (2) @(negedge clk);
        en[4] = 1'b0;
        fall_at = 0; prev_k = 1'b1; c = 0;
        while (busy_w[4] === 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
            if (prev_k === 1'b1 && key_w[4] === 1'b0) fall_at = c;
            prev_k = key_w[4];
        end
        check("busy drops after CHAR_GAP", c - fall_at, 12);
        key_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (key_w[4] === 1'b1 || busy_w[4] === 1'b1) key_seen = 1'b1;
        end
        check("stays idle after en drop", int'(key_seen), 0);
        check("idle char_idx", int'(idx_w[4]), 0);
        drain("drop");
        check("no extra runs", run_q[4].size(), 0);
        check("Q never strobed", stb_q[4].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
